// File: rtl/serial2parallel.sv
// Serial-to-parallel converter: a bit collector feeding a one-word holding register
// with a ready handshake and a sticky overrun flag.
module serial2parallel #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     serial_i,
  input  logic                     serial_valid_i,
  input  logic                     clear_i,
  input  logic                     ready_i,
  output logic [WIDTH-1:0]         parallel_o,
  output logic                     valid_o,
  output logic [$clog2(WIDTH)-1:0] count_o,
  output logic                     busy_o,
  output logic                     overrun_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_par;
  logic             r_ovr;

  logic [WIDTH-1:0] w_next_shift;
  logic             w_complete;

  always_comb begin
    w_next_shift = '0;
    if (MSB_FIRST != 0) begin
      w_next_shift = {r_shift[WIDTH-2:0], serial_i};
    end else begin
      w_next_shift = {serial_i, r_shift[WIDTH-1:1]};
    end
  end

  assign w_complete = serial_valid_i && (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= EMPTY;
      r_shift <= '0;
      r_count <= '0;
      r_par   <= '0;
      r_ovr   <= 1'b0;
    end else if (clear_i) begin
      r_state <= EMPTY;
      r_shift <= '0;
      r_count <= '0;
      r_par   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (serial_valid_i) begin
        r_shift <= w_next_shift;
        r_count <= w_complete ? '0 : r_count + CW'(1);
      end
      // Completed word goes straight from the shifter into the holding register.
      case (r_state)
        EMPTY: begin
          if (w_complete) begin
            r_state <= FULL;
            r_par   <= w_next_shift;
          end
        end
        FULL: begin
          if (w_complete) begin
            if (ready_i) begin
              r_par <= w_next_shift;
            end else begin
              r_ovr <= 1'b1;
            end
          end else if (ready_i) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign parallel_o = r_par;
  assign valid_o    = (r_state == FULL);
  assign count_o    = r_count;
  assign busy_o     = (r_count != '0);
  assign overrun_o  = r_ovr;

endmodule
